// File: rtl/param_counter_pkg.sv
// Shared types for the parametrised counter core: terminal-mode encoding.
package param_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

endpackage

// File: rtl/param_counter_if.sv
// Control and status bundle of the counter core; master drives controls, slave is the counter.
interface param_counter_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);

  logic                           enable;
  logic                           load;
  logic [WIDTH-1:0]               load_value;
  logic                           up;
  param_counter_pkg::mode_t       mode;
  logic [WIDTH-1:0]               max_value;
  logic [PRESCALE_W-1:0]          prescale;
  logic [WIDTH-1:0]               count;
  logic                           tc;
  logic                           done;

  modport master (
    output enable, load, load_value, up, mode, max_value, prescale,
    input  count, tc, done
  );

  modport slave (
    input  enable, load, load_value, up, mode, max_value, prescale,
    output count, tc, done
  );

endinterface

// File: rtl/counter_prescaler.sv
// Tick divider: combinational tick every prescale+1 enabled cycles; clear restarts the period.
// No backpressure; enable=0 freezes the divider.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] pre_cnt;

  // >= so that lowering prescale below the current phase fires immediately instead of stalling
  assign tick = enable & (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= pre_cnt + ONE;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with runtime load, modulus, prescaled tick and wrap/saturate/one-shot modes.
// count/tc/done are registered, one clock after the tick cycle; no backpressure, enable gates progress.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      PRESCALE_W  = 4
) (
  input  logic           clk,
  input  logic           reset,
  param_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick;
  logic             terminal;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] wrap_value;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             done_q;

  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .clear    (bus.load),
    .prescale (bus.prescale),
    .tick     (tick)
  );

  always_comb begin
    terminal     = bus.up ? (count_q >= bus.max_value) : (count_q == '0);
    step_value   = bus.up ? (count_q + ONE) : (count_q - ONE);
    wrap_value   = bus.up ? '0 : bus.max_value;
    load_clamped = (bus.load_value > bus.max_value) ? bus.max_value : bus.load_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else if (tick && !done_q) begin
      if (terminal) begin
        tc_q <= 1'b1;
        case (bus.mode)
          MODE_SAT:     count_q <= count_q;
          MODE_ONESHOT: done_q  <= 1'b1;
          default:      count_q <= wrap_value;
        endcase
      end else begin
        tc_q    <= 1'b0;
        count_q <= step_value;
      end
    end else begin
      // a finished one-shot swallows ticks, so tc stays low here too
      tc_q <= 1'b0;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_param_counter.sv
// Scenario tasks push expected count/tc/done per cycle into a scoreboard and pop after each edge.
module tb_param_counter;
  import param_counter_pkg::*;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  param_counter_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

  param_counter #(
    .WIDTH       (8),
    .RESET_VALUE (8'h10),
    .PRESCALE_W  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] c, input logic t, input logic d);
    exp_t e;
    e.count = c;
    e.tc    = t;
    e.done  = d;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    bus.enable = 1'b1; bus.load = 1'b0; bus.load_value = 8'h00; bus.up = 1'b1;
    bus.mode = MODE_WRAP; bus.max_value = 8'h05; bus.prescale = 4'd0;
    sb.push_back(mk(8'h10, 1'b0, 1'b0));
    sb.push_back(mk(8'h10, 1'b0, 1'b0));
    repeat (2) begin
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL reset: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
    reset = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic test_wrap();
    exp_t e;
    bus.load = 1'b1; bus.load_value = 8'h00;
    sb.push_back(mk(8'h00, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); vectors++;
    if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
      miscompares++;
      $display("FAIL wrap_load: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
               bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
    end
    bus.load = 1'b0; bus.enable = 1'b1;
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    sb.push_back(mk(8'd2, 1'b0, 1'b0));
    sb.push_back(mk(8'd3, 1'b0, 1'b0));
    sb.push_back(mk(8'd4, 1'b0, 1'b0));
    sb.push_back(mk(8'd5, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b1, 1'b0));
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    repeat (7) begin
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL wrap: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 8'd3;
    bus.mode = MODE_SAT; bus.up = 1'b0;
    sb.push_back(mk(8'd3, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.load = 1'b0; bus.enable = 1'b1;
    sb.push_back(mk(8'd2, 1'b0, 1'b0));
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b1, 1'b0));
    sb.push_back(mk(8'd0, 1'b1, 1'b0));
    sb.push_back(mk(8'd0, 1'b1, 1'b0));
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL saturate[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
    // enable low at the bound: count holds and tc drops
    bus.enable = 1'b0;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front(); vectors++;
    if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
      miscompares++;
      $display("FAIL sat_disable: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
               bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    logic [7:0] c;
    bus.load = 1'b1; bus.load_value = 8'd0; bus.mode = MODE_ONESHOT; bus.up = 1'b1;
    bus.max_value = 8'd3; bus.prescale = 4'd2;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      c = (k < 3) ? 8'd0 : (k < 6) ? 8'd1 : (k < 9) ? 8'd2 : 8'd3;
      sb.push_back(mk(c, k == 12, k >= 12));
    end
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL oneshot[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
    bus.load = 1'b1; bus.load_value = 8'd0;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.load = 1'b0;
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b0, 1'b0));
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL oneshot_reload[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
  endtask

  task automatic test_load_tick();
    exp_t e;
    // prescaler phase is 0 here; two enabled cycles bring it to the tick point
    bus.mode = MODE_WRAP; bus.max_value = 8'h20;
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    sb.push_back(mk(8'h20, 1'b0, 1'b0));
    sb.push_back(mk(8'h20, 1'b0, 1'b0));
    sb.push_back(mk(8'h20, 1'b0, 1'b0));
    sb.push_back(mk(8'h00, 1'b1, 1'b0));
    for (int k = 0; k < 6; k++) begin
      bus.load = (k == 2); bus.load_value = 8'hFF;
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL load_tick[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
      if (k == 2) begin
        vectors++;
        if (dut.u_prescaler.pre_cnt !== 4'd0) begin
          miscompares++;
          $display("FAIL load_tick_pre: pre_cnt=%0d expected 0", dut.u_prescaler.pre_cnt);
        end
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_max_lower();
    exp_t e;
    bus.prescale = 4'd0; bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 8'd10;
    sb.push_back(mk(8'd10, 1'b0, 1'b0));
    sb.push_back(mk(8'd10, 1'b0, 1'b0));
    sb.push_back(mk(8'd0, 1'b1, 1'b0));
    sb.push_back(mk(8'd1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      bus.load = (k == 0);
      bus.enable = (k >= 2);
      if (k == 2) bus.max_value = 8'd4;
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL max_lower[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    bus.max_value = 8'd20; bus.enable = 1'b0; bus.load = 1'b1; bus.load_value = 8'd5;
    sb.push_back(mk(8'd5, 1'b0, 1'b0));
    sb.push_back(mk(8'd6, 1'b0, 1'b0));
    sb.push_back(mk(8'd7, 1'b0, 1'b0));
    sb.push_back(mk(8'h10, 1'b0, 1'b0));
    sb.push_back(mk(8'h10, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      bus.load   = (k == 0 || k == 3);
      bus.load_value = (k == 3) ? 8'd3 : 8'd5;
      bus.enable = (k == 1 || k == 2 || k == 3);
      reset      = (k == 3);
      @(posedge clk); #1;
      e = sb.pop_front(); vectors++;
      if ({bus.count, bus.tc, bus.done} !== {e.count, e.tc, e.done}) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: count=%h tc=%b done=%b, expected count=%h tc=%b done=%b",
                 k, bus.count, bus.tc, bus.done, e.count, e.tc, e.done);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_load_tick();
    test_max_lower();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
